// File: rtl/masked_share_encoder.sv
// masked_share_encoder: splits plaintext operand bits a/b into two Boolean
// shares using mask bits from an internal 32-bit LFSR, and emits the shares
// plus three refresh bits in one registered output beat.
module masked_share_encoder #(
    parameter logic [31:0] SEED          = 32'h0000_0001,
    parameter logic [31:0] TAPS          = 32'h8020_0003,
    parameter int unsigned WARMUP_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        a,
    input  logic        b,
    input  logic        reseed_req,
    input  logic [31:0] seed_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        input1_0,
    output logic        input1_1,
    output logic        input2_0,
    output logic        input2_1,
    output logic        r0,
    output logic        r1,
    output logic        r2,
    output logic        busy
);

    typedef enum logic {
        S_WARMUP,
        S_RUN
    } state_t;

    // An all-zero LFSR would lock up, so zero seeds are replaced by 1.
    localparam logic [31:0] SEED_EFF    = (SEED == '0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] WARM_LAST   = WARMUP_CYCLES - 1;
    localparam state_t      START_STATE = (WARMUP_CYCLES == 0) ? S_RUN : S_WARMUP;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [31:0] warm_cnt;
    logic        accept;

    assign lfsr_next = {lfsr[30:0], ^(lfsr & TAPS)};
    assign accept    = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_WARMUP: begin
                busy = 1'b1;
                if (warm_cnt == WARM_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = !reseed_req && (!out_valid || out_ready);
            end
            default: begin
                state_nxt = START_STATE;
            end
        endcase
        if (reseed_req) begin
            state_nxt = START_STATE;
        end
    end

    // LFSR, warmup counter and registered output beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= SEED_EFF;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            input1_0  <= 1'b0;
            input1_1  <= 1'b0;
            input2_0  <= 1'b0;
            input2_1  <= 1'b0;
            r0        <= 1'b0;
            r1        <= 1'b0;
            r2        <= 1'b0;
        end else if (reseed_req) begin
            // Reseed wins over everything; a pending beat is dropped.
            lfsr      <= (seed_in == '0) ? 32'h0000_0001 : seed_in;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (state == S_WARMUP) begin
            lfsr     <= lfsr_next;
            warm_cnt <= (warm_cnt == WARM_LAST) ? '0 : warm_cnt + 32'd1;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            lfsr      <= lfsr_next;
            input1_0  <= a ^ lfsr[0];
            input1_1  <= lfsr[0];
            input2_0  <= b ^ lfsr[1];
            input2_1  <= lfsr[1];
            r0        <= lfsr[2];
            r1        <= lfsr[3];
            r2        <= lfsr[4];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_masked_share_encoder.sv
// Scoreboard bench for masked_share_encoder: stimulus pushes expected beats
// computed from a behavioural model; a monitor pops and compares them.
module tb_masked_share_encoder;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, a, b, reseed_req, out_valid, out_ready;
    logic        i10, i11, i20, i21, r0, r1, r2, busy;
    logic [31:0] seed_in;

    logic        z_in_valid, z_in_ready, z_a, z_b, z_reseed_req, z_out_valid, z_out_ready;
    logic        z_i10, z_i11, z_i20, z_i21, z_r0, z_r1, z_r2, z_busy;
    logic [31:0] z_seed_in;

    int n_cmp = 0;
    int n_bad = 0;
    int beats_in = 0;
    int beats_out = 0;

    // Expected entries: {a, b, input1_0, input1_1, input2_0, input2_1, r0, r1, r2}
    logic [8:0]  exp_q[$];
    logic [31:0] model;

    masked_share_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .reseed_req(reseed_req), .seed_in(seed_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .input1_0(i10), .input1_1(i11), .input2_0(i20), .input2_1(i21),
        .r0(r0), .r1(r1), .r2(r2), .busy(busy)
    );

    masked_share_encoder #(.WARMUP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .a(z_a), .b(z_b), .reseed_req(z_reseed_req), .seed_in(z_seed_in),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .input1_0(z_i10), .input1_1(z_i11), .input2_0(z_i20), .input2_1(z_i21),
        .r0(z_r0), .r1(z_r1), .r2(z_r2), .busy(z_busy)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], ^(s & TAPS)};
    endfunction

    // Masks are the two lowest state bits, refresh bits the next three.
    function automatic logic [6:0] encode(input logic [31:0] s, input logic pa, input logic pb);
        int unsigned m1, m2, r;
        m1 = s % 2;
        m2 = (s / 2) % 2;
        r  = (s / 4) % 8;
        return {pa ^ m1[0], m1[0], pb ^ m2[0], m2[0], r[0], r[1], r[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got out_valid=1 expected no beat");
            end else begin
                check("beat_data", {i10, i11, i20, i21, r0, r1, r2}, exp_q[0][6:0]);
                check("share_xor", {i10 ^ i11, i20 ^ i21}, exp_q[0][8:7]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats_out++;
                end
            end
        end
    end

    // Called at a negedge: records an accept that the next posedge performs.
    task automatic note_accept();
        if (in_valid && in_ready) begin
            exp_q.push_back({a, b, encode(model, a, b)});
            model = step(model);
            beats_in++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        note_accept();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles from now until in_ready rises, then takes the accept.
    task automatic warmup_check(input string name, input logic [31:0] seed);
        int nwait = 0;
        int nbusy = 0;
        int guard = 0;
        model = seed;
        for (int i = 0; i < 32; i++) model = step(model);
        while (guard < 200) begin
            @(negedge clk);
            if (guard == 0) check({name, "_no_beat"}, out_valid, 1'b0);
            if (in_ready) break;
            nwait++;
            if (busy) nbusy++;
            guard++;
            @(posedge clk);
            #1;
        end
        check({name, "_stall_cycles"}, nwait, 32);
        check({name, "_busy_cycles"}, nbusy, 32);
        note_accept();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; reseed_req = 0; seed_in = '0; out_ready = 1;
        z_in_valid = 0; z_a = 0; z_b = 0; z_reseed_req = 0; z_seed_in = '0; z_out_ready = 1;
        model = 32'h1;

        // Zero-warmup instance: immediate RUN and the first known beats.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        z_in_valid = 1; z_a = 1; z_b = 1;
        @(negedge clk);
        check("z_ready_after_reset", {z_in_ready, z_busy}, 2'b10);
        @(posedge clk); #1;
        z_a = 0; z_b = 1;
        @(negedge clk);
        check("z_beat1", {z_out_valid, z_i10, z_i11, z_i20, z_i21, z_r0, z_r1, z_r2}, 8'b1_0110000);
        @(posedge clk); #1;
        z_a = 0; z_b = 0;
        @(negedge clk);
        check("z_beat2", {z_out_valid, z_i10, z_i11, z_i20, z_i21, z_r0, z_r1, z_r2}, 8'b1_1101000);
        @(posedge clk); #1;
        z_in_valid = 0;
        @(negedge clk);
        // 0x3 steps to 0x6 under the stated feedback rule.
        check("z_beat3", {z_out_valid, z_i10, z_i11, z_i20, z_i21, z_r0, z_r1, z_r2},
              {1'b1, encode(step(step(32'h1)), 1'b0, 1'b0)});
        @(posedge clk); #1;
        @(negedge clk);
        check("z_drain", z_out_valid, 1'b0);
        @(posedge clk); #1;
        z_reseed_req = 1; z_seed_in = '0; z_in_valid = 1; z_a = 1; z_b = 1;
        @(negedge clk);
        check("z_reseed_blocks_accept", z_in_ready, 1'b0);
        @(posedge clk); #1;
        z_reseed_req = 0;
        @(negedge clk);
        check("z_after_reseed", {z_out_valid, z_busy, z_in_ready}, 3'b001);
        @(posedge clk); #1;
        z_in_valid = 0;
        @(negedge clk);
        check("z_reseed_beat", {z_out_valid, z_i10, z_i11, z_i20, z_i21, z_r0, z_r1, z_r2}, 8'b1_0110000);

        // Main instance: reset state, then warmup with in_valid held high.
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", {out_valid, in_ready, busy, i10, i11, i20, i21, r0, r1, r2}, 10'b0010000000);
        @(posedge clk); #1;
        exp_q.delete();
        beats_in = 0; beats_out = 0;
        rst = 1'b0;
        in_valid = 1; a = 1; b = 0; out_ready = 0;
        warmup_check("warmup_reset", 32'h1);

        // Backpressure: pending beat held for 5 cycles, then drain plus reload.
        a = 0; b = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            note_accept();
            @(posedge clk); #1;
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("bp_reload_valid", out_valid, 1'b1);
        @(posedge clk); #1;

        // Reseed with zero seed while a beat is pending.
        in_valid = 1; a = 1; b = 1; out_ready = 0;
        tick();
        reseed_req = 1; seed_in = '0;
        @(negedge clk);
        check("reseed_blocks_accept", in_ready, 1'b0);
        @(posedge clk); #1;
        reseed_req = 0;
        beats_in -= exp_q.size();
        exp_q.delete();
        a = $urandom_range(0, 1); b = $urandom_range(0, 1);
        warmup_check("warmup_reseed", 32'h1);

        // Random traffic with random backpressure.
        begin
            int target = beats_in + 1000;
            int guard = 0;
            while (beats_in < target && guard < 20000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                a         = $urandom_range(0, 1);
                b         = $urandom_range(0, 1);
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
                guard++;
            end
            check("random_beats_issued", beats_in >= target, 1'b1);
        end
        in_valid = 0; out_ready = 1;
        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        check("beat_count", beats_out, beats_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
